// File: rtl/branch_commit_unit_pkg.sv
// Shared definitions for the branch commit unit: FSM encoding, FIFO depth
// default and the saturating statistics counter helper.
package branch_commit_unit_pkg;

    typedef enum logic [0:0] {
        BCU_IDLE  = 1'b0,
        BCU_FLUSH = 1'b1
    } bcu_state_e;

    localparam int          UPD_DEPTH_DEFAULT = 4;
    localparam logic [31:0] CNT_SAT           = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == CNT_SAT) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/branch_commit_unit_upd_fifo.sv
// Predictor training FIFO of {pc, taken}. The extra pointer MSB tells full from
// empty; everything holds while rdy is low.
module upd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic        push_taken,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic [31:0] head_pc,
    output logic        head_taken
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [32:0]      mem_q [DEPTH];
    logic [32:0]      mem_d [DEPTH];
    logic [PTR_W-2:0] wr_idx;
    logic [PTR_W-2:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign wr_idx     = wr_ptr_q[PTR_W-2:0];
    assign rd_idx     = rd_ptr_q[PTR_W-2:0];
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);
    assign do_push    = rdy & push & ~full;
    assign do_pop     = rdy & pop & ~empty;
    assign head_pc    = mem_q[rd_idx][32:1];
    assign head_taken = mem_q[rd_idx][0];

    // Next pointers and storage contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            wr_ptr_d       = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            mem_d[wr_idx]  = {push_pc, push_taken};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset discards all pending entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/branch_commit_unit.sv
// Commit-side branch resolution: queues predictor training updates, raises a
// one-cycle flush with the redirect PC on a direction mispredict, keeps stats.
module branch_commit_unit
    import branch_commit_unit_pkg::*;
#(
    parameter int UPD_DEPTH = UPD_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic        commit_is_branch,
    input  logic [31:0] commit_pc,
    input  logic        commit_pred_taken,
    input  logic        commit_real_taken,
    input  logic [31:0] commit_next_pc,
    output logic        upd_valid,
    output logic [31:0] upd_pc,
    output logic        upd_taken,
    input  logic        upd_ready,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    bcu_state_e  state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        branch_acc;
    logic        mispredict;

    // Ready looks only at registered state so a same-cycle pop cannot raise it.
    assign commit_ready = (state_q == BCU_IDLE) & ~fifo_full;
    assign accept       = rdy & commit_valid & commit_ready;
    assign branch_acc   = accept & commit_is_branch;
    assign mispredict   = branch_acc & (commit_pred_taken != commit_real_taken);

    assign upd_valid        = ~fifo_empty;
    assign flush            = (state_q == BCU_FLUSH);
    assign redirect_pc      = redirect_pc_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

    upd_fifo #(
        .DEPTH(UPD_DEPTH)
    ) u_upd_fifo (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .push       (branch_acc),
        .push_pc    (commit_pc),
        .push_taken (commit_real_taken),
        .pop        (upd_valid & upd_ready),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_pc    (upd_pc),
        .head_taken (upd_taken)
    );

    // FSM next state, redirect latch and saturating statistics.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        stat_br_d     = stat_br_q;
        stat_mp_d     = stat_mp_q;
        if (rdy) begin
            case (state_q)
                BCU_IDLE:  state_d = mispredict ? BCU_FLUSH : BCU_IDLE;
                BCU_FLUSH: state_d = BCU_IDLE;
                default:   state_d = BCU_IDLE;
            endcase
            if (branch_acc) begin
                stat_br_d = sat_inc(stat_br_q);
            end else begin
                stat_br_d = stat_br_q;
            end
            if (mispredict) begin
                stat_mp_d     = sat_inc(stat_mp_q);
                redirect_pc_d = commit_next_pc;
            end else begin
                stat_mp_d     = stat_mp_q;
                redirect_pc_d = redirect_pc_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BCU_IDLE;
            redirect_pc_q <= 32'h0000_0000;
            stat_br_q     <= 32'h0000_0000;
            stat_mp_q     <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            stat_br_q     <= stat_br_d;
            stat_mp_q     <= stat_mp_d;
        end
    end

endmodule

// File: tb/tb_branch_commit_unit.sv
// Directed bench for branch_commit_unit: inputs change 1ns after each rising
// edge and outputs are checked in the same window.
module tb_branch_commit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        commit_valid;
    logic        commit_ready;
    logic        commit_is_branch;
    logic [31:0] commit_pc;
    logic        commit_pred_taken;
    logic        commit_real_taken;
    logic [31:0] commit_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_ready;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_commit_unit #(.UPD_DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .commit_valid      (commit_valid),
        .commit_ready      (commit_ready),
        .commit_is_branch  (commit_is_branch),
        .commit_pc         (commit_pc),
        .commit_pred_taken (commit_pred_taken),
        .commit_real_taken (commit_real_taken),
        .commit_next_pc    (commit_next_pc),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_taken         (upd_taken),
        .upd_ready         (upd_ready),
        .flush             (flush),
        .redirect_pc       (redirect_pc),
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        commit_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive_branch(input logic [31:0] pc, input logic pred, input logic real_t,
                                input logic [31:0] npc);
        commit_valid      = 1'b1;
        commit_is_branch  = 1'b1;
        commit_pc         = pc;
        commit_pred_taken = pred;
        commit_real_taken = real_t;
        commit_next_pc    = npc;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid got=%b exp=0", upd_valid); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush); end
        checks++; if (commit_ready !== 1'b1) begin errors++; $display("FAIL reset_commit_ready got=%b exp=1", commit_ready); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got=%h exp=0", redirect_pc); end
        checks++; if (stat_branches !== 32'h0) begin errors++; $display("FAIL reset_stat_br got=%h exp=0", stat_branches); end
        checks++; if (stat_mispredicts !== 32'h0) begin errors++; $display("FAIL reset_stat_mp got=%h exp=0", stat_mispredicts); end
    endtask

    task automatic test_correct_prediction();
        drive_branch(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0104);
        step();
        commit_valid = 1'b0;
        checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL corr_upd_valid got=%b exp=1", upd_valid); end
        checks++; if (upd_pc !== 32'h0000_0100) begin errors++; $display("FAIL corr_upd_pc got=%h exp=00000100", upd_pc); end
        checks++; if (upd_taken !== 1'b1) begin errors++; $display("FAIL corr_upd_taken got=%b exp=1", upd_taken); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL corr_flush got=%b exp=0", flush); end
        checks++; if (stat_branches !== 32'd1) begin errors++; $display("FAIL corr_stat_br got=%0d exp=1", stat_branches); end
        step();
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL corr_drained got=%b exp=0", upd_valid); end
    endtask

    task automatic test_mispredict();
        drive_branch(32'h0000_0200, 1'b0, 1'b1, 32'h0000_0240);
        step();
        commit_valid = 1'b0;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mis_flush got=%b exp=1", flush); end
        checks++; if (redirect_pc !== 32'h0000_0240) begin errors++; $display("FAIL mis_redirect got=%h exp=00000240", redirect_pc); end
        checks++; if (commit_ready !== 1'b0) begin errors++; $display("FAIL mis_ready got=%b exp=0", commit_ready); end
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h0000_0200 || upd_taken !== 1'b1) begin
            errors++; $display("FAIL mis_update got=%b/%h/%b exp=1/00000200/1", upd_valid, upd_pc, upd_taken); end
        step();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mis_flush_end got=%b exp=0", flush); end
        checks++; if (commit_ready !== 1'b1) begin errors++; $display("FAIL mis_ready_back got=%b exp=1", commit_ready); end
        checks++; if (stat_mispredicts !== 32'd1) begin errors++; $display("FAIL mis_stat_mp got=%0d exp=1", stat_mispredicts); end
        checks++; if (stat_branches !== 32'd2) begin errors++; $display("FAIL mis_stat_br got=%0d exp=2", stat_branches); end
    endtask

    task automatic test_non_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            commit_valid      = 1'b1;
            commit_is_branch  = 1'b0;
            commit_pc         = 32'h0000_0500 + 32'(4 * i);
            commit_pred_taken = 1'b0;
            commit_real_taken = 1'b1;
            commit_next_pc    = 32'h0000_0900;
            step();
            checks++; if (upd_valid !== 1'b0 || flush !== 1'b0) begin
                errors++; $display("FAIL nb_no_effect[%0d] got=%b/%b exp=0/0", i, upd_valid, flush); end
        end
        commit_valid = 1'b0;
        checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++; $display("FAIL nb_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts); end
    endtask

    task automatic test_backpressure();
        do_reset();
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_branch(32'h0000_1000 + 32'(4 * i), i[0], i[0], 32'h0);
            checks++; if (commit_ready !== 1'b1) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=1", i, commit_ready); end
            step();
        end
        drive_branch(32'h0000_1010, 1'b0, 1'b0, 32'h0);
        checks++; if (commit_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", commit_ready); end
        step();
        checks++; if (stat_branches !== 32'd4) begin errors++; $display("FAIL bp_stall_stat got=%0d exp=4", stat_branches); end
        upd_ready = 1'b1;
        checks++; if (commit_ready !== 1'b0 || upd_pc !== 32'h0000_1000 || upd_taken !== 1'b0) begin
            errors++; $display("FAIL bp_head0 got=%b/%h/%b exp=0/00001000/0", commit_ready, upd_pc, upd_taken); end
        step();
        checks++; if (commit_ready !== 1'b1 || upd_pc !== 32'h0000_1004 || upd_taken !== 1'b1) begin
            errors++; $display("FAIL bp_head1 got=%b/%h/%b exp=1/00001004/1", commit_ready, upd_pc, upd_taken); end
        step();
        commit_valid = 1'b0;
        checks++; if (upd_pc !== 32'h0000_1008 || upd_taken !== 1'b0 || stat_branches !== 32'd5) begin
            errors++; $display("FAIL bp_head2 got=%h/%b/%0d exp=00001008/0/5", upd_pc, upd_taken, stat_branches); end
        step();
        checks++; if (upd_pc !== 32'h0000_100C || upd_taken !== 1'b1) begin
            errors++; $display("FAIL bp_head3 got=%h/%b exp=0000100c/1", upd_pc, upd_taken); end
        step();
        checks++; if (upd_valid !== 1'b1 || upd_pc !== 32'h0000_1010 || upd_taken !== 1'b0) begin
            errors++; $display("FAIL bp_head4 got=%b/%h/%b exp=1/00001010/0", upd_valid, upd_pc, upd_taken); end
        step();
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", upd_valid); end
    endtask

    task automatic test_rdy_gating();
        do_reset();
        drive_branch(32'h0000_0300, 1'b1, 1'b0, 32'h0000_0304);
        step();
        commit_valid = 1'b0;
        rdy = 1'b0;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rdy_flush_start got=%b exp=1", flush); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (flush !== 1'b1 || upd_valid !== 1'b1 || upd_pc !== 32'h0000_0300) begin
                errors++; $display("FAIL rdy_hold[%0d] got=%b/%b/%h exp=1/1/00000300", i, flush, upd_valid, upd_pc); end
            checks++; if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1 || redirect_pc !== 32'h0000_0304) begin
                errors++; $display("FAIL rdy_stats[%0d] got=%0d/%0d/%h exp=1/1/00000304", i, stat_branches, stat_mispredicts, redirect_pc); end
        end
        rdy = 1'b1;
        step();
        checks++; if (flush !== 1'b0 || upd_valid !== 1'b0) begin
            errors++; $display("FAIL rdy_resume got=%b/%b exp=0/0", flush, upd_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        upd_ready = 1'b0;
        drive_branch(32'h0000_0400, 1'b1, 1'b1, 32'h0000_0404);
        step();
        drive_branch(32'h0000_0404, 1'b0, 1'b1, 32'h0000_0500);
        step();
        commit_valid = 1'b0;
        checks++; if (flush !== 1'b1 || stat_branches !== 32'd2) begin
            errors++; $display("FAIL rm_pre got=%b/%0d exp=1/2", flush, stat_branches); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (upd_valid !== 1'b0 || flush !== 1'b0 || commit_ready !== 1'b1) begin
            errors++; $display("FAIL rm_ctrl got=%b/%b/%b exp=0/0/1", upd_valid, flush, commit_ready); end
        checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0 || redirect_pc !== 32'h0) begin
            errors++; $display("FAIL rm_regs got=%0d/%0d/%h exp=0/0/0", stat_branches, stat_mispredicts, redirect_pc); end
        upd_ready = 1'b1;
    endtask

    initial begin
        rst               = 1'b1;
        rdy               = 1'b1;
        commit_valid      = 1'b0;
        commit_is_branch  = 1'b0;
        commit_pc         = 32'h0;
        commit_pred_taken = 1'b0;
        commit_real_taken = 1'b0;
        commit_next_pc    = 32'h0;
        upd_ready         = 1'b1;
        test_reset();
        test_correct_prediction();
        test_mispredict();
        test_non_branch();
        test_backpressure();
        test_rdy_gating();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
